// File: rtl/dso_decimator.sv
// dso_decimator: reduces the 8-bit ADC stream on ad_clk to one sample per
// block of 2^deci_shift inputs. The reduction is sample, average or
// alternating peak (max/min).
module dso_decimator #(
  parameter int SHIFT_W = 4,
  parameter int ACC_W   = 23
) (
  input  logic               ad_clk,
  input  logic               rst,
  input  logic               wave_run,
  input  logic [SHIFT_W-1:0] deci_shift,
  input  logic [1:0]         deci_mode,
  input  logic [7:0]         ad_data,
  output logic               deci_valid,
  output logic [7:0]         deci_data,
  output logic               deci_phase
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_AVG  = 2'd1;
  localparam logic [1:0] MODE_PEAK = 2'd2;

  state_t             state;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [1:0]         cfg_mode;
  logic [14:0]        cnt;
  logic [ACC_W-1:0]   acc;
  logic [7:0]         max_r;
  logic [7:0]         min_r;
  logic [7:0]         first_r;
  logic               pk_tgl;

  logic               start;
  logic [SHIFT_W-1:0] eff_shift;
  logic [1:0]         eff_mode;
  logic [14:0]        last_cnt;
  logic               last;
  logic [ACC_W-1:0]   acc_n;
  logic [7:0]         max_n;
  logic [7:0]         min_n;
  logic [7:0]         first_n;
  logic [7:0]         avg;
  logic               tgl_eff;

  // Next-sample datapath. At a block start the live config inputs are used
  // directly, so the sample captured on that edge already follows the new
  // block's shift and mode (needed for shift 0, where that sample is also the last).
  always_comb begin
    start     = (state == IDLE) || (cnt == 15'd0);
    eff_shift = start ? deci_shift : cfg_shift;
    eff_mode  = start ? deci_mode : cfg_mode;
    last_cnt  = ~(15'h7fff << eff_shift);
    last      = (cnt == last_cnt);
    acc_n     = start ? ACC_W'(ad_data) : acc + ACC_W'(ad_data);
    max_n     = (start || ad_data > max_r) ? ad_data : max_r;
    min_n     = (start || ad_data < min_r) ? ad_data : min_r;
    first_n   = start ? ad_data : first_r;
    avg       = 8'(acc_n >> eff_shift);
    tgl_eff   = (start && eff_mode == MODE_PEAK && cfg_mode != MODE_PEAK) ? 1'b0 : pk_tgl;
  end

  // Two-state run/idle control, block accumulation and the registered outputs.
  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cfg_shift  <= '0;
      cfg_mode   <= '0;
      cnt        <= '0;
      acc        <= '0;
      max_r      <= '0;
      min_r      <= '0;
      first_r    <= '0;
      pk_tgl     <= 1'b0;
      deci_valid <= 1'b0;
      deci_data  <= '0;
      deci_phase <= 1'b0;
    end else if (!wave_run) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      max_r      <= '0;
      min_r      <= '0;
      first_r    <= '0;
      pk_tgl     <= 1'b0;
      deci_valid <= 1'b0;
    end else begin
      state <= RUN;
      if (start) begin
        cfg_shift <= deci_shift;
        cfg_mode  <= deci_mode;
      end
      acc        <= acc_n;
      max_r      <= max_n;
      min_r      <= min_n;
      first_r    <= first_n;
      pk_tgl     <= tgl_eff;
      cnt        <= last ? 15'd0 : cnt + 15'd1;
      deci_valid <= last;
      if (last) begin
        case (eff_mode)
          MODE_AVG: begin
            deci_data  <= avg;
            deci_phase <= 1'b0;
          end
          MODE_PEAK: begin
            deci_data  <= tgl_eff ? min_n : max_n;
            deci_phase <= ~tgl_eff;
            pk_tgl     <= ~tgl_eff;
          end
          default: begin
            deci_data  <= first_n;
            deci_phase <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dso_decimator.sv
// Scoreboard bench for dso_decimator: a behavioural block model pushes the
// expected output for every completed block; each observed strobe is popped and checked.
module tb_dso_decimator;

  logic       ad_clk = 1'b0;
  logic       rst = 1'b1;
  logic       wave_run = 1'b0;
  logic [3:0] deci_shift = '0;
  logic [1:0] deci_mode = '0;
  logic [7:0] ad_data = '0;
  logic       deci_valid;
  logic [7:0] deci_data;
  logic       deci_phase;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int  data;
    int  phase;
    time t;
  } exp_t;

  exp_t exp_q[$];
  int   blk[$];
  int   m_shift = 0;
  int   m_mode = 0;
  bit   m_tgl = 1'b0;

  dso_decimator #(.SHIFT_W(4), .ACC_W(23)) dut (
    .ad_clk(ad_clk),
    .rst(rst),
    .wave_run(wave_run),
    .deci_shift(deci_shift),
    .deci_mode(deci_mode),
    .ad_data(ad_data),
    .deci_valid(deci_valid),
    .deci_data(deci_data),
    .deci_phase(deci_phase)
  );

  always #5 ad_clk = ~ad_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: collects a block of samples, reduces it when complete.
  always @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      blk.delete();
      exp_q.delete();
      m_tgl = 1'b0;
      m_mode = 0;
      m_shift = 0;
    end else if (!wave_run) begin
      blk.delete();
      m_tgl = 1'b0;
    end else begin
      if (blk.size() == 0) begin
        if (deci_mode == 2 && m_mode != 2) m_tgl = 1'b0;
        m_shift = int'(deci_shift);
        m_mode  = int'(deci_mode);
      end
      blk.push_back(int'(ad_data));
      if (blk.size() == (1 << m_shift)) begin
        exp_t e;
        int sum, mx, mn;
        sum = 0; mx = 0; mn = 255;
        foreach (blk[i]) begin
          sum += blk[i];
          if (blk[i] > mx) mx = blk[i];
          if (blk[i] < mn) mn = blk[i];
        end
        e.t = $time;
        e.phase = 0;
        if (m_mode == 1) e.data = (sum >> m_shift) & 255;
        else if (m_mode == 2) begin
          e.data  = m_tgl ? mn : mx;
          e.phase = m_tgl ? 0 : 1;
          m_tgl   = ~m_tgl;
        end else e.data = blk[0];
        exp_q.push_back(e);
        blk.delete();
      end
    end
  end

  // Output monitor, half a cycle after the registering edge.
  always @(negedge ad_clk) begin
    if (!rst && deci_valid) begin
      if (exp_q.size() == 0) chk("extra_strobe", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data", int'(deci_data), e.data);
        chk("phase", int'(deci_phase), e.phase);
        chk("latency", int'($time - e.t), 5);
      end
    end
  end

  task automatic step(input bit run, input int d);
    @(negedge ad_clk);
    wave_run = run;
    ad_data = 8'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic set_cfg(input int sh, input int md);
    deci_shift = 4'(sh);
    deci_mode = 2'(md);
  endtask

  initial begin
    repeat (2) @(negedge ad_clk);
    chk("rst_valid", int'(deci_valid), 0);
    chk("rst_data", int'(deci_data), 0);
    chk("rst_phase", int'(deci_phase), 0);
    rst = 1'b0;
    idle(2);

    // shift 0 ramp: continuous strobes, data delayed by one cycle
    set_cfg(0, 0);
    for (int i = 0; i < 16; i++) step(1'b1, i);
    idle(3);

    // sample mode, shift 2
    set_cfg(2, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 10 + i);
    idle(3);

    // average mode, shift 3: 255 then 28
    set_cfg(3, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 255);
    for (int i = 0; i < 8; i++) step(1'b1, 8 * i);
    idle(3);
    chk("avg_drained", exp_q.size(), 0);

    // peak mode, shift 2: 200/phase1 then 1/phase0
    set_cfg(2, 2);
    step(1'b1, 5); step(1'b1, 200); step(1'b1, 3); step(1'b1, 90);
    step(1'b1, 7); step(1'b1, 1); step(1'b1, 250); step(1'b1, 9);
    step(1'b1, 40); step(1'b1, 60); step(1'b1, 50); step(1'b1, 30);
    // switch to sample then back to peak: toggle restarts at max
    set_cfg(1, 0);
    step(1'b1, 33); step(1'b1, 44);
    set_cfg(1, 2);
    step(1'b1, 17); step(1'b1, 99); step(1'b1, 120); step(1'b1, 80);
    idle(3);

    // peak at shift 0: phase alternates every cycle
    set_cfg(0, 2);
    for (int i = 0; i < 6; i++) step(1'b1, 3 * i + 1);
    idle(3);

    // reserved mode behaves as sample mode
    set_cfg(1, 3);
    for (int i = 0; i < 6; i++) step(1'b1, 100 - i);
    idle(3);

    // mid-block config change 2 -> 1 after cnt = 1
    set_cfg(2, 0);
    step(1'b1, 60); step(1'b1, 61);
    set_cfg(1, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 62 + i);
    idle(3);

    // run drop at cnt = 2, then a fresh full block
    set_cfg(2, 0);
    step(1'b1, 70); step(1'b1, 71); step(1'b1, 72);
    idle(2);
    for (int i = 0; i < 8; i++) step(1'b1, 80 + i);
    idle(3);
    chk("drop_drained", exp_q.size(), 0);

    // run drop on the last-sample edge: no strobe for that block
    set_cfg(1, 1);
    step(1'b1, 90);
    step(1'b0, 91);
    idle(2);

    // reset mid-run clears outputs asynchronously
    set_cfg(0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 77);
    @(posedge ad_clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(deci_valid), 0);
    chk("midrst_data", int'(deci_data), 0);
    chk("midrst_phase", int'(deci_phase), 0);
    @(negedge ad_clk);
    rst = 1'b0;
    set_cfg(2, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 4 * i);
    idle(3);

    // average at shift 15, constant 255: no overflow
    set_cfg(15, 1);
    for (int i = 0; i < 32768; i++) step(1'b1, 255);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
